// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one word fetch per
// cycle while space remains, buffers returned {pc, inst} pairs for IF/ID and
// flushes/restarts on a taken branch or jump redirect.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Stall,
  output logic        mem_Req,
  output logic [31:0] mem_Addr,
  input  logic [31:0] mem_Inst,
  output logic        I_Valid,
  output logic [31:0] I_PC,
  output logic [31:0] I_PC4,
  output logic [31:0] I_Inst
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_q_inst [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic          r_kill;

  logic [AW:0]   w_occ;
  logic          w_req;
  logic          w_push;
  logic          w_pop;

  // Occupancy counts the outstanding fetch so a response always has a slot.
  assign w_occ  = r_count + {{AW{1'b0}}, r_inflight};
  assign w_req  = Rst_n & ~Redirect & (w_occ < DEPTH_C);
  // A response landing in a redirect cycle is stale; the flush drops it.
  assign w_push = r_inflight & ~r_kill & ~Redirect;
  assign w_pop  = (r_count != '0) & ~Stall & ~Redirect;

  assign mem_Req  = w_req;
  assign mem_Addr = r_fetch_pc;
  assign I_Valid  = (r_count != '0);
  assign I_PC     = r_q_pc[r_rd_ptr];
  assign I_PC4    = I_PC + 32'd4;
  assign I_Inst   = I_Valid ? r_q_inst[r_rd_ptr] : 32'h0000_0000;

  // Fetch PC, pointers, occupancy and in-flight/kill tracking.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
    end else if (Redirect) begin
      r_fetch_pc <= RedirectPC & 32'hFFFF_FFFC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_kill     <= r_inflight;
      r_inflight <= 1'b0;
    end else begin
      r_kill <= 1'b0;
      if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Queue storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
      end
    end else if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_inflight_pc;
      r_q_inst[r_wr_ptr] <= mem_Inst;
    end
  end

endmodule
